phase_sequencer: RTL
====================

// Module: phase_sequencer
// PURPOSE
//  Generates the 3-bit phase number that drives the multicycle control decoder.
//  The datapath runs five phases per instruction: P1 fetch, P2 decode/read, P3 execute,
//  P4 memory, P5 writeback. Phase 0 means idle: all control outputs are inactive.
//  Adds run/stop control, single-step, HLT detection, memory-wait stall and an instruction counter.
// PARAMETERS
//  NUM_PHASES  5   last active phase number; phases 1..NUM_PHASES are in use, legal range 2..7
//  HALT_PHASE  2   phase in which hlt_dec is sampled; IR is valid from this phase on
//  CNT_W       16  width of the retired-instruction counter
// PORTS
//  clk        in   1      system clock; all state changes on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  exec       in   1      run/stop button, level, synchronised outside; acted on at its rising edge
//  step_mode  in   1      1 = run one instruction per exec edge
//  hlt_dec    in   1      1 = IR holds HLT (op=2'b11, alu_op=4'b1111)
//  mem_wait   in   1      1 = memory not ready; freezes the sequencer in P1 and P4 only
//  phase      out  3      current phase, 0 = idle
//  running    out  1      1 while in state RUN
//  halted     out  1      1 while in state HALT
//  inst_done  out  1      one-cycle pulse on the cycle that leaves the last phase, or on HLT retire
//  inst_cnt   out  CNT_W  count of retired instructions, HLT included
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, phase=0, running=0, halted=0, inst_done=0, inst_cnt=0,
//   exec_q=0, stop_pend=0. The first exec edge after rst deasserts is honoured.
//  exec_rise = exec & ~exec_q, where exec_q is registered every cycle.
//  States: IDLE, RUN, HALT.
//  IDLE: phase=0. On exec_rise -> RUN with phase=1 on the next cycle.
//  RUN: phase advances by 1 each cycle, except:
//   - holds when mem_wait=1 and phase is 1 or 4;
//   - phase=HALT_PHASE and hlt_dec=1 -> HALT, phase=0, inst_done pulse, inst_cnt+1;
//   - phase=NUM_PHASES -> inst_done pulse and inst_cnt+1. Then:
//       if step_mode=1 or stop_pend=1 -> IDLE and clear stop_pend; else phase=1.
//  stop_pend: set on exec_rise while in RUN. The current instruction always completes.
//  HALT: phase=0, halted=1. exec_rise -> RUN at phase=1; the PC is owned outside.
//  Simultaneous events, in priority order:
//   1. rst
//   2. hlt_dec at HALT_PHASE, taken even if mem_wait=1 (HALT_PHASE is not 1 or 4)
//   3. mem_wait hold
//   4. advance
//  exec_rise in the same cycle as the last phase sets stop_pend, so the sequencer
//   returns to IDLE at the end of this instruction.
//  inst_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//  phase is a registered output; it never holds 0 while in RUN and never exceeds NUM_PHASES.
//  inst_done is registered: high for exactly one cycle, coincident with the first cycle
//   of the next phase or state.
//  rst asserted mid-instruction forces phase=0 immediately; no inst_done is produced.
// STRUCTURE
//  Shared package phase_pkg:
//   - PH_IDLE=3'd0, PH_FETCH=3'd1, PH_DEC=3'd2, PH_EXE=3'd3, PH_MEM=3'd4, PH_WB=3'd5
//   - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
//   - the control decoder imports the same phase constants.
//  One sub-module, rise_detect: 1-bit registered edge detector with async rst; used for exec.
//  Everything else is a single always block for the state/phase/count registers.
// TESTING
//  1. rst pulse, then one exec edge, step_mode=0, hlt_dec=0
//     -> phase 1,2,3,4,5,1,...; inst_done every 5th cycle; inst_cnt=3 after 15 cycles.
//  2. step_mode=1, exec edge
//     -> phase 1..5 then 0; inst_cnt=1; running=0; a second edge gives inst_cnt=2.
//  3. hlt_dec=1 during phase 2
//     -> next phase=0, halted=1, inst_cnt+1; later edges keep phase=0 until exec.
//  4. mem_wait=1 for 3 cycles entering P4
//     -> phase stays 4 for 4 cycles total, then 5.
//     mem_wait in P3 has no effect (3 goes to 4).
//  5. exec edge in P3 while running
//     -> instruction completes through P5, then phase=0, state IDLE.
//  6. rst asserted in P4
//     -> phase=0 asynchronously, inst_cnt=0, no inst_done.
//     With CNT_W=4 preset, 16 retirements wrap inst_cnt to 0.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared phase/state encodings for the multicycle sequencer and the control decoder.
package phase_pkg;

  localparam int unsigned PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PH_IDLE  = 3'd0;
  localparam logic [PHASE_W-1:0] PH_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PH_DEC   = 3'd2;
  localparam logic [PHASE_W-1:0] PH_EXE   = 3'd3;
  localparam logic [PHASE_W-1:0] PH_MEM   = 3'd4;
  localparam logic [PHASE_W-1:0] PH_WB    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Phases that touch memory and therefore honour mem_wait.
  function automatic logic is_mem_phase(input logic [PHASE_W-1:0] ph);
    return (ph == PH_FETCH) || (ph == PH_MEM);
  endfunction

endpackage

// File: rtl/phase_sequencer_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on the cycle d_i first reads high.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_c_o = d_i & ~d_q;

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with run/stop, single-step, HLT, memory-wait stall
// and a retired-instruction counter.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int unsigned NUM_PHASES = int'(PH_WB),
  parameter int unsigned HALT_PHASE = int'(PH_DEC),
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic               step_mode,
  input  logic               hlt_dec,
  input  logic               mem_wait,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               inst_done,
  output logic [CNT_W-1:0]   inst_cnt
);

  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES);
  localparam logic [PHASE_W-1:0] HLT_PH  = PHASE_W'(HALT_PHASE);

  logic               exec_rise_c;
  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               stop_pend_q, stop_pend_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               running_q, halted_q;

  rise_detect u_exec_rise (
    .clk      (clk),
    .rst      (rst),
    .d_i      (exec),
    .rise_c_o (exec_rise_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_IDLE;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      running_q   <= (state_d == ST_RUN);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  // Priority inside RUN: HLT retire, then memory stall, then advance/retire.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        phase_d = PH_IDLE;
        if (exec_rise_c) begin
          state_d = ST_RUN;
          phase_d = PH_FETCH;
        end
      end

      ST_RUN: begin
        if (exec_rise_c) begin
          stop_pend_d = 1'b1;
        end
        if ((phase_q == HLT_PH) && hlt_dec) begin
          state_d     = ST_HALT;
          phase_d     = PH_IDLE;
          done_d      = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          stop_pend_d = 1'b0;
        end else if (mem_wait && is_mem_phase(phase_q)) begin
          phase_d = phase_q;
        end else if (phase_q == LAST_PH) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          // A stop request arriving on the last phase still ends this instruction.
          if (step_mode || stop_pend_q || exec_rise_c) begin
            state_d     = ST_IDLE;
            phase_d     = PH_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            phase_d = PH_FETCH;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end

      ST_HALT: begin
        phase_d = PH_IDLE;
        if (exec_rise_c) begin
          state_d = ST_RUN;
          phase_d = PH_FETCH;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        phase_d     = PH_IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  assign phase     = phase_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign inst_done = done_q;
  assign inst_cnt  = cnt_q;

endmodule
